// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_param pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } seq_state_e;

  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 2) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a fill counter that saturates at len-1.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               shift,
  input  logic               clr,
  input  logic               x,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-2:0] hist,
  output logic [LEN_W-1:0]   fill
);

  // Only len-1 past bits are ever compared, so the register is one bit short of MAX_LEN.
  localparam int HW = MAX_LEN - 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= (hist << 1) | HW'(x);
      if (fill < len - LEN_W'(1)) fill <= fill + LEN_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with a zero-latency Mealy match strobe.
// Define SEQ_DET_HIT_CNT_EN to build the saturating hit counter; otherwise hit_cnt is tied to 0.
//
// state | meaning
// IDLE  | no valid pattern loaded; samples ignored
// FILL  | collecting bits, fill < len-1
// ARMED | fill >= len-1; every sample may complete a match
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               x,
  input  logic               x_valid,
  input  logic               ovl_mode,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               z,
  output logic               armed,
  output logic               cfg_err,
  input  logic               hit_clr,
  output logic [CNT_W-1:0]   hit_cnt
);

  seq_state_e         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               cfg_err_q;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               hist_shift, hist_clr;
  logic               cfg_ok, sample, match;
  logic [MAX_LEN-1:0] window, mask;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk     (clk),
    .reset_n (reset_n),
    .shift   (hist_shift),
    .clr     (hist_clr),
    .x       (x),
    .len     (len_q),
    .hist    (hist),
    .fill    (fill)
  );

  assign cfg_ok = len_legal(int'(cfg_len), MAX_LEN);
  // A load owns the cycle: the bit presented alongside it is never sampled.
  assign sample = en & x_valid & (state_q != IDLE) & ~cfg_load;
  assign armed  = (state_q == ARMED);

  assign window = {hist, x};
  assign mask   = ~({MAX_LEN{1'b1}} << len_q);
  assign match  = ((window ^ pat_q) & mask) == '0;
  assign z      = sample & armed & match;

  assign cfg_err = cfg_err_q;

  always_comb begin
    state_d    = state_q;
    hist_shift = 1'b0;
    hist_clr   = 1'b0;
    if (cfg_load) begin
      if (cfg_ok) begin
        state_d  = FILL;
        hist_clr = 1'b1;
      end
    end else if (sample) begin
      if (z && !ovl_mode) begin
        state_d  = FILL;
        hist_clr = 1'b1;
      end else begin
        hist_shift = 1'b1;
        if (state_q == FILL && fill == len_q - LEN_W'(2)) state_d = ARMED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        if (cfg_ok) begin
          pat_q     <= cfg_pattern;
          len_q     <= cfg_len;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_W-1:0] hit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 hit_q <= '0;
    else if (hit_clr)             hit_q <= '0;
    else if (z && hit_q != '1)    hit_q <= hit_q + CNT_W'(1);
  end

  assign hit_cnt = hit_q;
`else
  logic unused_hit_clr;
  assign unused_hit_clr = hit_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: bit-window reference model plus directed literal checks.
module tb_seq_det_param;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               en = 1'b0, x = 1'b0, x_valid = 1'b0, ovl_mode = 1'b0;
  logic               cfg_load = 1'b0, hit_clr = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               z, armed, cfg_err;
  logic [CNT_W-1:0]   hit_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_det_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .x           (x),
    .x_valid     (x_valid),
    .ovl_mode    (ovl_mode),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .z           (z),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .hit_clr     (hit_clr),
    .hit_cnt     (hit_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int hits);
`ifdef SEQ_DET_HIT_CNT_EN
    return (hits > CNT_MAX) ? CNT_MAX : hits;
`else
    return 0;
`endif
  endfunction

  // Reference model: the pattern, and the list of accepted bits since the last clear.
  bit                 m_loaded = 0;
  int                 m_len = 0;
  logic [MAX_LEN-1:0] m_pat = '0;
  bit                 m_bits[$];
  bit                 m_err = 0;
  int                 m_cnt = 0;

  always @(negedge clk) begin
    bit smp, e_armed, e_z, b;
    int n;
    if (!reset_n) begin
      m_loaded = 0; m_len = 0; m_pat = '0; m_bits.delete(); m_err = 0; m_cnt = 0;
      check("rst_z", {31'b0, z}, 32'd0);
      check("rst_armed", {31'b0, armed}, 32'd0);
      check("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
      check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    end else begin
      n       = m_bits.size();
      e_armed = m_loaded && (n >= m_len - 1);
      smp     = en && x_valid && m_loaded && !cfg_load;
      e_z     = 0;
      if (smp && e_armed) begin
        e_z = 1;
        for (int j = 0; j < m_len; j++) begin
          b = (j == m_len - 1) ? x : m_bits[n - (m_len - 1) + j];
          if (b != m_pat[m_len - 1 - j]) e_z = 0;
        end
      end
      check("cyc_z", {31'b0, z}, {31'b0, e_z});
      check("cyc_armed", {31'b0, armed}, {31'b0, e_armed});
      check("cyc_cfg_err", {31'b0, cfg_err}, {31'b0, m_err});
      check("cyc_hit_cnt", 32'(hit_cnt), 32'(m_cnt));

      if (cfg_load) begin
        if (int'(cfg_len) >= 2 && int'(cfg_len) <= MAX_LEN) begin
          m_loaded = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_bits.delete(); m_err = 0;
        end else begin
          m_err = 1;
        end
      end else if (smp) begin
        if (e_z && !ovl_mode) m_bits.delete();
        else begin
          m_bits.push_back(x);
          if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        end
      end
`ifdef SEQ_DET_HIT_CNT_EN
      if (hit_clr) m_cnt = 0;
      else if (e_z && m_cnt < CNT_MAX) m_cnt++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int l);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l);
    tick();
    cfg_load = 1'b0; x_valid = 1'b0;
  endtask

  task automatic clear_cnt();
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
  endtask

  // Cycle k drives xs/vs/hc bit [n-1-k] (first bit is MSB) and records z into zs[k].
  task automatic run_seq(input logic [31:0] xs, input logic [31:0] vs, input logic [31:0] hc,
                         input int n, output logic [31:0] zs);
    zs = '0;
    for (int k = 0; k < n; k++) begin
      x = xs[n-1-k]; x_valid = vs[n-1-k]; hit_clr = hc[n-1-k];
      @(negedge clk);
      zs[k] = z;
      tick();
    end
    x = 1'b0; x_valid = 1'b0; hit_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] zs;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("init_armed", {31'b0, armed}, 32'd0);
    check("init_cfg_err", {31'b0, cfg_err}, 32'd0);
    check("init_hit_cnt", 32'(hit_cnt), 32'd0);

    // Overlapping 101010; a valid bit during the load cycle must be discarded.
    ovl_mode = 1'b1; x = 1'b1; x_valid = 1'b1;
    load(16'b101010, 6);
    clear_cnt();
    run_seq(32'b101010101010, 32'hFFF, 32'h0, 12, zs);
    check("ovl_z", zs, 32'b1010_1010_0000);
    check("ovl_hit_cnt", 32'(hit_cnt), 32'(exp_cnt(4)));

    // Non-overlap: only indices 5 and 11.
    ovl_mode = 1'b0;
    load(16'b101010, 6);
    clear_cnt();
    run_seq(32'b101010101010, 32'hFFF, 32'h0, 12, zs);
    check("novl_z", zs, 32'b1000_0010_0000);
    check("novl_hit_cnt", 32'(hit_cnt), 32'(exp_cnt(2)));

    // Valid gap is transparent.
    ovl_mode = 1'b1;
    load(16'b101010, 6);
    run_seq(32'b1010_111_10, 32'b1111_000_11, 32'h0, 9, zs);
    check("gap_z", zs, 32'h100);

    // Illegal lengths keep the old configuration and history.
    load(16'h0001, 1);
    check("len1_cfg_err", {31'b0, cfg_err}, 32'd1);
    check("len1_armed", {31'b0, armed}, 32'd1);
    load(16'hFFFF, MAX_LEN + 1);
    check("len17_cfg_err", {31'b0, cfg_err}, 32'd1);
    check("len17_armed", {31'b0, armed}, 32'd1);
    run_seq(32'b10, 32'b11, 32'h0, 2, zs);
    check("old_pat_z", zs, 32'b10);
    load(16'b1100, 4);
    check("relegal_cfg_err", {31'b0, cfg_err}, 32'd0);
    check("relegal_armed", {31'b0, armed}, 32'd0);
    run_seq(32'b1100, 32'hF, 32'h0, 4, zs);
    check("len4_z", zs, 32'b1000);

    // Maximum length pattern.
    ovl_mode = 1'b0;
    load(16'hA5C3, MAX_LEN);
    run_seq(32'hA5C3, 32'hFFFF, 32'h0, 16, zs);
    check("maxlen_z", zs, 32'h8000);
    check("maxlen_armed_after", {31'b0, armed}, 32'd0);

    // Minimum length, overlapping; en=0 freezes history.
    ovl_mode = 1'b1;
    load(16'b11, 2);
    run_seq(32'b1111, 32'hF, 32'h0, 4, zs);
    check("len2_z", zs, 32'b1110);
    en = 1'b0;
    run_seq(32'b11, 32'b11, 32'h0, 2, zs);
    check("en_off_z", zs, 32'd0);
    check("en_off_armed", {31'b0, armed}, 32'd1);
    en = 1'b1;
    run_seq(32'b1, 32'b1, 32'h0, 1, zs);
    check("en_on_z", zs, 32'd1);

    // Reset mid-stream requires a fresh load.
    load(16'b101010, 6);
    run_seq(32'b1010, 32'hF, 32'h0, 4, zs);
    reset_n = 1'b0;
    #2;
    check("midrst_z", {31'b0, z}, 32'd0);
    check("midrst_armed", {31'b0, armed}, 32'd0);
    tick();
    reset_n = 1'b1;
    run_seq(32'b101010, 32'h3F, 32'h0, 6, zs);
    check("postrst_z", zs, 32'd0);
    check("postrst_armed", {31'b0, armed}, 32'd0);

    // Counter saturation, then clear wins over a simultaneous hit.
    load(16'b101010, 6);
    clear_cnt();
    run_seq(32'b10101010101010, 32'h3FFF, 32'h0, 14, zs);
    check("sat_z", zs, 32'h2AA0);
    check("sat_hit_cnt", 32'(hit_cnt), 32'(exp_cnt(5)));
    run_seq(32'b10, 32'b11, 32'b01, 2, zs);
    check("clr_z", zs, 32'b10);
    check("clr_hit_cnt", 32'(hit_cnt), 32'd0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised, runtime-programmable serial bit-pattern detector for single-bit streams.
- Successor to the fixed 6-bit hard-coded Mealy detectors in the design. Adds:
  - programmable pattern and length
  - overlap / non-overlap mode
  - input valid qualifier
  - config error flag
  - optional saturating hit counter
- Sits between serial front-end samplers and control logic needing a one-cycle match strobe.

Parameters:
- MAX_LEN, 16: maximum pattern length in bits, 2..32.
- LEN_W, $clog2(MAX_LEN+1): width of the length field. Derived; do not override.
- CNT_W, 16: hit counter width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  detector enable; 0 freezes history and forces z=0
- x  in  1  serial data bit
- x_valid  in  1  x is sampled only when 1
- ovl_mode  in  1  1 = overlapping matches allowed; 0 = history cleared after each match
- cfg_load  in  1  one-cycle strobe; latch cfg_pattern and cfg_len
- cfg_pattern  in  MAX_LEN  pattern bits; bit [cfg_len-1] is the first bit expected on x
- cfg_len  in  LEN_W  pattern length
- z  out  1  Mealy match strobe, combinational from current x
- armed  out  1  history holds at least len-1 valid bits
- cfg_err  out  1  sticky; last load was rejected
- hit_clr  in  1  synchronous clear of hit_cnt
- hit_cnt  out  CNT_W  saturating match count

Behaviour:
- Reset (asynchronous on reset_n low):
  - pat=0, len=0, hist=0, fill=0, cfg_err=0, hit_cnt=0.
  - State goes to IDLE; z=0, armed=0.
- States:
  - IDLE: no valid pattern loaded.
  - FILL: fill < len-1.
  - ARMED: fill >= len-1.
- Load:
  - cfg_load with 2 <= cfg_len <= MAX_LEN:
    - latch pat and len; clear hist, fill and cfg_err.
    - Next state FILL.
    - A bit presented in the load cycle is discarded.
  - cfg_load with an illegal length:
    - set cfg_err; keep the previous pat, len, state and history.
  - cfg_load has priority over sampling in the same cycle.
- Sample condition: en & x_valid & state != IDLE.
  - On each sample, hist shifts left and takes x.
  - fill increments, saturating at len-1.
- Match, combinational in the sample cycle: z = sample & armed & ({hist[len-2:0], x} == pat[len-1:0]).
  - Zero latency: z is asserted in the same cycle as the final pattern bit.
- After a match:
  - ovl_mode=1: history keeps shifting normally; state remains ARMED.
  - ovl_mode=0: hist and fill are cleared at the clock edge; state returns to FILL, so the next match needs len fresh bits.
- Transitions:
  - FILL to ARMED when fill reaches len-1.
  - ARMED to FILL only on a non-overlap match or on a load.
  - ovl_mode is sampled each match cycle; changing it mid-stream is legal.
- Masked cycles:
  - x_valid=0 or en=0: no shift, z=0, state unchanged. Gaps are transparent to the pattern.
- Reset mid-stream: everything returns to IDLE, and a new cfg_load is required.

Optional Feature:
- Macro: SEQ_DET_HIT_CNT_EN.
- Defined:
  - hit_cnt increments on each z=1 cycle and saturates at 2^CNT_W-1.
  - hit_clr clears it; hit_clr wins over a simultaneous hit.
- Undefined:
  - hit_cnt is tied to 0 and hit_clr is ignored.
  - No counter flops are synthesised.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE, FILL, ARMED), 2 bits
  - the legal-length check function
  - the default MAX_LEN constant
- One sub-module, seq_det_hist: shift register plus fill counter.
  - Inputs: shift, clr.
  - Outputs: hist, fill.
- Compare, FSM and counter stay in the top module.

Test Plan:
- Load pattern 101010, len 6, ovl=1; drive 101010101010, valid every cycle -> z high at bit indices 5, 7, 9, 11; hit_cnt=4 with macro.
- Same load, ovl=0, same stream -> z high only at indices 5 and 11.
- Len 6 as above, ovl=1, stream 1010 then x_valid=0 for 3 cycles then 10 -> single z on the last bit; z=0 throughout the gap.
- Load len=1, then len=MAX_LEN+1 -> cfg_err=1, old pattern still matches, state unchanged. A following legal load clears cfg_err.
- Mid-stream: after 4 bits of 101010, pulse reset_n low -> z=0, armed=0, state IDLE. Subsequent bits give no match until a cfg_load.
- Macro on, CNT_W=2: five overlapping matches -> hit_cnt sticks at 3. Assert hit_clr during a match cycle -> hit_cnt=0.
